// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SPI-mode SD card responder.
package sd_spi_pkg;

  // Command indices the responder understands
  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  // R1 status bits
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] R1_PARAM   = 8'h40;

  // Fixed bytes on MISO
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] FILL       = 8'hFF;

  localparam logic [15:0] DEFAULT_BLK_LEN = 16'd512;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_FRAME,
    NCR,
    RESP,
    DELAY,
    TOKEN,
    DATA,
    CRC
  } resp_state_e;

endpackage

// File: rtl/sd_byte_shifter.sv
// Parallel-load, MSB-first byte serializer shared by every MISO phase.
module sd_byte_shifter
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_bit,
  output logic [2:0] o_bit_cnt,
  output logic       o_byte_done
);

  logic [7:0] r_sr;
  logic [2:0] r_cnt;

  // Load a new byte or shift the current one left, back-filling with ones
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_sr  <= FILL;
      r_cnt <= 3'd0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= 3'd0;
    end else begin
      r_sr  <= {r_sr[6:0], 1'b1};
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_bit       = r_sr[7];
  assign o_bit_cnt   = r_cnt;
  assign o_byte_done = (r_cnt == 3'd7);

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: command decode, R1/R7 responses, single-block reads.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int ACMD41_RETRIES   = 2,
  parameter int NCR_BYTES        = 1,
  parameter int READ_DELAY_BYTES = 2,
  parameter int MAX_BLOCK        = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        in_idle,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index
);

  resp_state_e r_state, w_state_next;
  logic [5:0]  r_bit_cnt;
  logic [38:0] r_frame;          // frame bits 46..8 (transmission bit, index, argument)
  logic [15:0] r_cnt, w_cnt_next; // bytes already sent in the current phase
  logic        w_load, w_echo_shift;
  logic [7:0]  w_load_data;
  logic        w_sh_bit, w_sh_done;
  logic [2:0]  w_sh_cnt;

  logic        r_initialized, r_app_flag, r_in_idle;
  logic [7:0]  r_busy_cnt;
  logic [15:0] r_blk_len;
  logic [7:0]  r_r1;
  logic        r_echo_en, r_do_read;
  logic [31:0] r_echo, r_mem_addr;
  logic        r_cmd_valid;
  logic [5:0]  r_cmd_index;

  logic        w_decode;
  logic [5:0]  w_cmd;
  logic [31:0] w_arg;
  logic [7:0]  w_base, w_r1, w_busy_n;
  logic        w_echo, w_read, w_init_n, w_idle_n, w_app_n;
  logic [15:0] w_blk_n;

  assign w_cmd    = r_frame[37:32];
  assign w_arg    = r_frame[31:0];
  // cs_n high on the end-bit clock wins: the frame is dropped
  assign w_decode = (r_state == RX_FRAME) && (r_bit_cnt == 6'd47) && !cs_n && r_frame[38];

  // Count frame bits; the start bit (47) is the first 0 seen while idle
  always_ff @(posedge clk) begin
    if (reset || cs_n)               r_bit_cnt <= 6'd0;
    else if (r_state == RX_IDLE)     r_bit_cnt <= mosi ? 6'd0 : 6'd1;
    else if (r_state == RX_FRAME)    r_bit_cnt <= r_bit_cnt + 6'd1;
    else                             r_bit_cnt <= 6'd0;
  end

  // Capture frame bits 46..8; CRC7 and end bit are never needed
  always_ff @(posedge clk) begin
    // NOTE: pure datapath register, fully rewritten before use, so it carries no reset.
    if (r_state == RX_FRAME && r_bit_cnt <= 6'd39) r_frame <= {r_frame[37:0], mosi};
  end

  // Command decode: response byte and next card state
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_base   = {7'b0, r_in_idle};
    w_r1     = w_base;
    w_echo   = 1'b0;
    w_read   = 1'b0;
    w_init_n = r_initialized;
    w_idle_n = r_in_idle;
    w_app_n  = 1'b0;
    w_busy_n = r_busy_cnt;
    w_blk_n  = r_blk_len;
    if (!r_initialized && w_cmd != CMD0) begin
      w_r1    = R1_IDLE | R1_ILLEGAL;
      w_app_n = r_app_flag;
    end else begin
      case (w_cmd)
        CMD0: begin
          w_init_n = 1'b1;
          w_idle_n = 1'b1;
          w_busy_n = 8'(ACMD41_RETRIES);
          w_blk_n  = DEFAULT_BLK_LEN;
          w_r1     = R1_IDLE;
        end
        CMD8:  w_echo  = 1'b1;
        CMD55: w_app_n = 1'b1;
        CMD41: begin
          if (!r_app_flag)              w_r1 = w_base | R1_ILLEGAL;
          else if (r_busy_cnt != 8'd0) begin
            w_busy_n = r_busy_cnt - 8'd1;
            w_r1     = R1_IDLE;
          end else begin
            w_idle_n = 1'b0;
            w_r1     = 8'h00;
          end
        end
        CMD16: begin
          if (w_arg != 32'd0 && w_arg <= 32'(MAX_BLOCK)) w_blk_n = w_arg[15:0];
          else                                            w_r1    = w_base | R1_PARAM;
        end
        CMD17: begin
          if (r_in_idle) w_r1 = R1_IDLE | R1_ILLEGAL;
          else begin
            w_r1   = 8'h00;
            w_read = 1'b1;
          end
        end
        default: w_r1 = w_base | R1_ILLEGAL;
      endcase
    end
  end

  // Card state and latched response; only reset clears card state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_initialized <= 1'b0;
      r_app_flag    <= 1'b0;
      r_in_idle     <= 1'b1;
      r_busy_cnt    <= 8'(ACMD41_RETRIES);
      r_blk_len     <= DEFAULT_BLK_LEN;
      r_r1          <= FILL;
      r_echo_en     <= 1'b0;
      r_do_read     <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_index   <= 6'd0;
    end else begin
      r_cmd_valid <= w_decode;
      if (w_decode) begin
        r_initialized <= w_init_n;
        r_app_flag    <= w_app_n;
        r_in_idle     <= w_idle_n;
        r_busy_cnt    <= w_busy_n;
        r_blk_len     <= w_blk_n;
        r_r1          <= w_r1;
        r_echo_en     <= w_echo;
        r_do_read     <= w_read;
        r_cmd_index   <= w_cmd;
      end
    end
  end

  // CMD8 echo bytes leave MSB byte first
  always_ff @(posedge clk) begin
    if (w_decode)          r_echo <= w_arg;
    else if (w_echo_shift) r_echo <= {r_echo[23:0], 8'h00};
  end

  // Block address: seeded by CMD17, advanced after each memory read
  always_ff @(posedge clk) begin
    if (reset)                   r_mem_addr <= 32'd0;
    else if (w_decode && w_read) r_mem_addr <= w_arg;
    else if (mem_rd)             r_mem_addr <= r_mem_addr + 32'd1;
  end

  // Response sequencer: picks the next byte at each byte boundary
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_load_data  = FILL;
    w_echo_shift = 1'b0;
    case (r_state)
      RX_IDLE:  if (!mosi) w_state_next = RX_FRAME;
      RX_FRAME: begin
        if (r_bit_cnt == 6'd47) begin
          if (r_frame[38]) begin
            w_state_next = NCR;
            w_load       = 1'b1;
            w_cnt_next   = 16'd0;
          end else begin
            w_state_next = RX_IDLE;
          end
        end
      end
      NCR: if (w_sh_done) begin
        w_load = 1'b1;
        if (r_cnt == 16'(NCR_BYTES - 1)) begin
          w_state_next = RESP;
          w_load_data  = r_r1;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      RESP: if (w_sh_done) begin
        if (r_echo_en && r_cnt < 16'd4) begin
          w_load       = 1'b1;
          w_load_data  = r_echo[31:24];
          w_echo_shift = 1'b1;
          w_cnt_next   = r_cnt + 16'd1;
        end else if (r_do_read) begin
          w_state_next = DELAY;
          w_load       = 1'b1;
          w_cnt_next   = 16'd0;
        end else begin
          w_state_next = RX_IDLE;
        end
      end
      DELAY: if (w_sh_done) begin
        w_load = 1'b1;
        if (r_cnt == 16'(READ_DELAY_BYTES - 1)) begin
          w_state_next = TOKEN;
          w_load_data  = DATA_TOKEN;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      TOKEN: if (w_sh_done) begin
        w_state_next = DATA;
        w_load       = 1'b1;
        w_load_data  = mem_data;
        w_cnt_next   = 16'd0;
      end
      DATA: if (w_sh_done) begin
        w_load = 1'b1;
        if (r_cnt == r_blk_len - 16'd1) begin
          w_state_next = CRC;
          w_cnt_next   = 16'd0;
        end else begin
          w_load_data = mem_data;
          w_cnt_next  = r_cnt + 16'd1;
        end
      end
      CRC: if (w_sh_done) begin
        if (r_cnt == 16'd1) begin
          w_state_next = RX_IDLE;
        end else begin
          w_load     = 1'b1;
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
    if (cs_n) begin
      w_state_next = RX_IDLE;
      w_load       = 1'b0;
    end
  end

  // Sequencer state and phase byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  sd_byte_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .o_bit      (w_sh_bit),
    .o_bit_cnt  (w_sh_cnt),
    .o_byte_done(w_sh_done)
  );

  // Fetch the next block byte two bits before the current byte ends
  assign mem_rd    = !cs_n && (w_sh_cnt == 3'd6) &&
                     ((r_state == TOKEN) || ((r_state == DATA) && (r_cnt != r_blk_len - 16'd1)));
  assign mem_addr  = r_mem_addr;
  assign miso      = (r_state == RX_IDLE || r_state == RX_FRAME) ? 1'b1 : w_sh_bit;
  assign in_idle   = r_in_idle;
  assign cmd_valid = r_cmd_valid;
  assign cmd_index = r_cmd_index;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: drives SPI frames and checks MISO bytes.
module tb_sd_spi_responder;

  logic        clk = 1'b0;
  logic        reset, cs_n, mosi;
  logic        miso, mem_rd, in_idle, cmd_valid;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic [5:0]  cmd_index;

  logic [7:0]  tb_mem [0:4095];
  logic [31:0] addr_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_valid  = 0;
  logic [7:0]  b;

  always #5 clk = ~clk;

  sd_spi_responder dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .in_idle  (in_idle),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index)
  );

  // Synchronous byte memory: data valid one clock after mem_rd
  always @(posedge clk) if (mem_rd) mem_data <= tb_mem[mem_addr[11:0]];

  // Monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) n_valid++;
    if (mem_rd === 1'b1) addr_q.push_back(mem_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [47:0] frame(input logic [5:0] idx, input logic [31:0] arg,
                                        input logic [7:0] crc);
    return {2'b01, idx, arg, crc};
  endfunction

  // Drive 48 bits; optionally raise cs_n together with the end bit
  task automatic send_frame(input logic [47:0] f, input bit drop_cs);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      mosi = f[i];
      if (drop_cs && i == 0) cs_n = 1'b1;
    end
  endtask

  task automatic get_byte(output logic [7:0] v);
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mosi = 1'b1;
      v = {v[6:0], miso};
    end
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] e);
    logic [7:0] v;
    get_byte(v);
    check(tag, {24'h0, v}, {24'h0, e});
  endtask

  task automatic gap();
    repeat (16) begin
      @(negedge clk);
      mosi = 1'b1;
    end
  endtask

  // Command with NCR filler and single R1 byte
  task automatic cmd_r1(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [7:0] r1);
    send_frame(frame(idx, arg, 8'h01), 1'b0);
    exp_byte({tag, "_ncr"}, 8'hFF);
    exp_byte({tag, "_r1"}, r1);
  endtask

  task automatic full_read(input string tag);
    cmd_r1(tag, 6'd17, 32'h100, 8'h00);
    exp_byte({tag, "_dly0"}, 8'hFF);
    exp_byte({tag, "_dly1"}, 8'hFF);
    exp_byte({tag, "_tok"}, 8'hFE);
    exp_byte({tag, "_d0"}, 8'h11);
    exp_byte({tag, "_d1"}, 8'h22);
    exp_byte({tag, "_d2"}, 8'h33);
    exp_byte({tag, "_d3"}, 8'h44);
    exp_byte({tag, "_crc0"}, 8'hFF);
    exp_byte({tag, "_crc1"}, 8'hFF);
    exp_byte({tag, "_idle"}, 8'hFF);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tb_mem[i] = 8'h55;
    tb_mem[12'h100] = 8'h11;
    tb_mem[12'h101] = 8'h22;
    tb_mem[12'h102] = 8'h33;
    tb_mem[12'h103] = 8'h44;

    reset = 1'b1;
    cs_n  = 1'b1;
    mosi  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'h0, miso}, 32'd1);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'd0);
    check("rst_cmd_index", {26'h0, cmd_index}, 32'd0);
    check("rst_in_idle", {31'h0, in_idle}, 32'd1);
    reset = 1'b0;
    cs_n  = 1'b0;
    gap();

    // Before CMD0 everything else is rejected without echo
    cmd_r1("pre_cmd8", 6'd8, 32'h1AA, 8'h05);
    exp_byte("pre_cmd8_noecho", 8'hFF);
    gap();

    // Frame with transmission bit 0 is dropped silently
    send_frame(48'h00_00_00_00_00_01, 1'b0);
    exp_byte("badframe_miso", 8'hFF);
    gap();
    check("badframe_valid", n_valid, 32'd1);

    cmd_r1("cmd0", 6'd0, 32'h0, 8'h01);
    gap();
    check("cmd0_index", {26'h0, cmd_index}, 32'd0);
    check("cmd0_valid", n_valid, 32'd2);
    check("cmd0_idle", {31'h0, in_idle}, 32'd1);

    cmd_r1("cmd8", 6'd8, 32'h1AA, 8'h01);
    exp_byte("cmd8_e0", 8'h00);
    exp_byte("cmd8_e1", 8'h00);
    exp_byte("cmd8_e2", 8'h01);
    exp_byte("cmd8_e3", 8'hAA);
    gap();
    check("cmd8_index", {26'h0, cmd_index}, 32'd8);

    cmd_r1("cmd17_idle", 6'd17, 32'h100, 8'h05);
    exp_byte("cmd17_idle_notok", 8'hFF);
    exp_byte("cmd17_idle_notok2", 8'hFF);
    exp_byte("cmd17_idle_notok3", 8'hFF);
    gap();

    cmd_r1("cmd55_a", 6'd55, 32'h0, 8'h01);
    gap();
    cmd_r1("acmd41_a", 6'd41, 32'h40000000, 8'h01);
    gap();
    cmd_r1("cmd55_b", 6'd55, 32'h0, 8'h01);
    gap();
    cmd_r1("acmd41_b", 6'd41, 32'h40000000, 8'h01);
    gap();
    cmd_r1("cmd55_c", 6'd55, 32'h0, 8'h01);
    gap();
    cmd_r1("acmd41_c", 6'd41, 32'h40000000, 8'h00);
    gap();
    check("init_in_idle", {31'h0, in_idle}, 32'd0);

    cmd_r1("cmd41_noapp", 6'd41, 32'h40000000, 8'h04);
    gap();
    cmd_r1("cmd5", 6'd5, 32'h0, 8'h04);
    gap();
    cmd_r1("cmd16_512", 6'd16, 32'd512, 8'h00);
    gap();
    cmd_r1("cmd16_4", 6'd16, 32'd4, 8'h00);
    gap();
    cmd_r1("cmd16_0", 6'd16, 32'd0, 8'h40);
    gap();
    cmd_r1("cmd16_513", 6'd16, 32'd513, 8'h40);
    gap();

    // cs_n rising with the end bit discards the command
    send_frame(frame(6'd16, 32'd1, 8'h01), 1'b1);
    gap();
    cs_n = 1'b0;
    gap();
    check("csabort_valid", n_valid, 32'd16);

    addr_q.delete();
    full_read("read1");
    gap();
    check("read1_nreads", addr_q.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < addr_q.size()) check("read1_addr", addr_q[k], 32'h100 + k);

    // Drop cs_n in the middle of the second data byte
    send_frame(frame(6'd17, 32'h100, 8'h01), 1'b0);
    for (int i = 0; i < 6; i++) get_byte(b);
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    check("abort_miso", {31'h0, miso}, 32'd1);
    gap();
    cs_n = 1'b0;
    gap();

    full_read("read2");
    gap();
    check("final_valid", n_valid, 32'd19);
    check("final_in_idle", {31'h0, in_idle}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
Synthesizable SPI-mode SD card emulator. It is the card-side responder for the SD host command sequencer. It decodes 48-bit command frames on MOSI and returns R1/R7 responses and single-block read data on MISO. Block data comes from an external byte memory. It is used in simulation and on-board loopback to bring up the host without a physical card.

Parameters:
ACMD41_RETRIES, 2, number of ACMD41 polls that answer 0x01 before the card leaves idle
NCR_BYTES, 1, 0xFF filler bytes between the command end bit and R1 (range 1..8)
READ_DELAY_BYTES, 2, 0xFF bytes between the CMD17 R1 and the data token 0xFE
MAX_BLOCK, 512, maximum legal CMD16 block length in bytes

Ports:
clk  in  1  SD serial clock; all logic on posedge
reset  in  1  synchronous, active-high
cs_n  in  1  chip select, active-low
mosi  in  1  host-to-card serial data, MSB first
miso  out  1  card-to-host serial data, MSB first, idles high
mem_addr  out  32  byte address of the next block byte
mem_rd  out  1  read strobe; mem_data is valid 1 clk later
mem_data  in  8  block byte from memory
in_idle  out  1  card idle flag (R1 bit0)
cmd_valid  out  1  1-clk pulse when a frame is decoded
cmd_index  out  6  index of the last decoded command; held until the next decode

Behaviour:
- Reset state:
  - Outputs: miso=1, mem_rd=0, mem_addr=0, cmd_valid=0, cmd_index=0, in_idle=1.
  - Internal: initialized=0, app_flag=0, busy_cnt=ACMD41_RETRIES, blk_len=512.
  - FSM in RX_IDLE.
- Reset mid-operation aborts any frame or response immediately.
- cs_n high: FSM forced to RX_IDLE, miso=1, frame counter cleared, mem_rd=0. Card state (in_idle, app_flag, busy_cnt, blk_len, initialized) is retained; only reset clears it.
- FSM states: RX_IDLE, RX_FRAME, NCR, RESP, DELAY, TOKEN, DATA, CRC.
  - RX_IDLE: the first sampled mosi=0 with cs_n=0 is frame bit 47. Move to RX_FRAME with bit count 1.
  - RX_FRAME: shift mosi into a 48-bit register. When the 48th bit is sampled, decode it, pulse cmd_valid, and go to NCR. Bit 46 must be 1; if not, discard the frame and return to RX_IDLE with no cmd_valid. CRC7 and end bit are ignored.
  - NCR: emit NCR_BYTES×0xFF, starting on the clk after the end bit. Then RESP.
  - RESP: emit the R1 byte, then 4 echo bytes (CMD8 only, arg[31:0] MSB byte first). Then DELAY for a successful CMD17, otherwise RX_IDLE.
  - DELAY: emit READ_DELAY_BYTES×0xFF, then TOKEN.
  - TOKEN: emit 0xFE, then DATA.
  - DATA: emit blk_len bytes. Byte k comes from mem_addr = arg + k (32-bit wrap). mem_rd pulses 1 clk before the byte loads into the shifter.
  - CRC: emit 0xFF, 0xFF, then RX_IDLE.
- mosi is ignored outside RX_IDLE/RX_FRAME.
- Each output byte takes exactly 8 clks. miso changes only on posedge.
- Command decode. Base R1 = {7'b0, in_idle}. ILLEGAL=0x04, PARAM=0x40.
  - Before the first CMD0: every command except CMD0 gets R1=0x05 and no state change.
  - CMD0: initialized=1, in_idle=1, busy_cnt=ACMD41_RETRIES, blk_len=512. R1=0x01.
  - CMD8: R1=base, then echo arg.
  - CMD55: app_flag=1, R1=base.
  - CMD41 with app_flag:
    - If busy_cnt>0: busy_cnt--, R1=0x01.
    - Otherwise: in_idle=0, R1=0x00.
  - CMD41 without app_flag: R1=base|ILLEGAL.
  - CMD16:
    - 1≤arg≤MAX_BLOCK: blk_len=arg, R1=base.
    - Otherwise: R1=base|PARAM, blk_len unchanged.
  - CMD17:
    - in_idle=1: R1=0x05, no data.
    - Otherwise: R1=0x00, followed by the data phase.
  - Any other index: R1=base|ILLEGAL.
  - Every command except CMD55 clears app_flag after decode.
- Simultaneous events: cs_n deassert has priority over a decode on the same clk; that command is discarded with no state change and no cmd_valid.

Decomposition:
- Package sd_spi_pkg holds:
  - command index constants (CMD0, CMD8, CMD16, CMD17, CMD41, CMD55)
  - R1 bit masks (IDLE, ILLEGAL, PARAM)
  - DATA_TOKEN=8'hFE and FILL=8'hFF
  - the responder state enum
- One sub-module, sd_byte_shifter: parallel-load 8-bit MSB-first shift-out with a bit counter and a byte_done pulse. It is reused for all output phases.

Test Plan:
- Reset, then CMD0 frame 40 00 00 00 00 95 -> after 8×NCR_BYTES clks of miso=1, R1=0x01; cmd_index=0; cmd_valid one pulse.
- CMD0, then CMD8 (arg 0x000001AA, crc 87) -> R1=0x01 followed by bytes 00 00 01 AA.
- CMD0, then CMD55+ACMD41 (arg 0x40000000) repeated three times -> R1 sequence 0x01, 0x01, 0x00, then in_idle=0. A CMD41 sent without a preceding CMD55 -> 0x04.
- After init, CMD16 arg 4 then CMD17 arg 0x100, memory preloaded with bytes 11 22 33 44 -> R1=0x00, 2×0xFF, FE, 11 22 33 44, FF FF. mem_addr steps 0x100..0x103.
- CMD16 arg 0 -> R1=0x40 and blk_len stays 4. CMD17 before init (in_idle=1) -> R1=0x05 with no token. Unknown CMD5 -> 0x04.
- cs_n raised midway through the DATA phase -> miso=1 the next clk. A new CMD17 is accepted and completes normally, and blk_len is still 4.
